// File: rtl/desc_fifo_reader.sv
// -----------------------------------------------------------------------------
// desc_fifo_reader
//   Consumer on the read port of a show-ahead descriptor FIFO. Pops descriptors,
//   drops those carrying the discard flag (MSB), and forwards the rest through a
//   2-entry output buffer onto a valid/ready interface. Keeps wrap-around counts
//   of forwarded (accepted downstream) and dropped descriptors.
//
// Ports
//   clk           : single clock
//   aclr          : synchronous active-high reset
//   i_enable      : 1 = pops allowed, 0 = pause popping (buffer still drains)
//   fifo_q        : FIFO show-ahead head word (valid while fifo_rdempty = 0)
//   fifo_rdempty  : FIFO empty flag
//   fifo_rdreq    : FIFO pop (combinational from registered state + FIFO flags)
//   o_data        : head entry of the output buffer
//   o_valid       : o_data valid (buffer non-empty)
//   i_ready       : downstream accepts o_data
//   o_fwd_cnt     : descriptors accepted downstream (wraps)
//   o_drop_cnt    : descriptors discarded (wraps)
//   o_busy        : buffer non-empty or FIFO non-empty
// -----------------------------------------------------------------------------
module desc_fifo_reader #(
  parameter int unsigned DataWidth = 22,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 i_enable,
  input  logic [DataWidth-1:0] fifo_q,
  input  logic                 fifo_rdempty,
  output logic                 fifo_rdreq,
  output logic [DataWidth-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CntWidth-1:0]  o_fwd_cnt,
  output logic [CntWidth-1:0]  o_drop_cnt,
  output logic                 o_busy
);

  localparam int unsigned FlagBit = DataWidth - 1;

  // Output buffer: head is always the presented word, tail is the second entry.
  logic [DataWidth-1:0] r_head;
  logic [DataWidth-1:0] r_tail;
  logic [1:0]           r_count;
  logic [CntWidth-1:0]  r_fwd_cnt;
  logic [CntWidth-1:0]  r_drop_cnt;

  logic w_valid;
  logic w_discard;
  logic w_pop;
  logic w_pop_fwd;
  logic w_pop_drop;
  logic w_xfer;

  assign w_valid   = (r_count != 2'd0);
  assign w_discard = fifo_q[FlagBit];

  // Discards never occupy the buffer, so they may be popped even when it is full.
  assign w_pop      = !aclr && i_enable && !fifo_rdempty &&
                      (w_discard || (r_count < 2'd2));
  assign w_pop_fwd  = w_pop && !w_discard;
  assign w_pop_drop = w_pop && w_discard;
  assign w_xfer     = w_valid && i_ready;

  // Buffer occupancy, contents and statistics.
  always_ff @(posedge clk) begin
    if (aclr) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= 2'd0;
      r_fwd_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      case ({w_pop_fwd, w_xfer})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head  <= fifo_q;
            r_count <= 2'd1;
          end else begin
            r_tail  <= fifo_q;
            r_count <= 2'd2;
          end
        end
        2'b01: begin
          if (r_count == 2'd2) begin
            r_head <= r_tail;
          end
          r_count <= r_count - 2'd1;
        end
        // Simultaneous pop and transfer only possible at count = 1:
        // the new word replaces the departing head, occupancy unchanged.
        2'b11: begin
          r_head <= fifo_q;
        end
        default: begin
        end
      endcase

      if (w_xfer) begin
        r_fwd_cnt <= r_fwd_cnt + CntWidth'(1);
      end
      if (w_pop_drop) begin
        r_drop_cnt <= r_drop_cnt + CntWidth'(1);
      end
    end
  end

  assign fifo_rdreq = w_pop;
  assign o_data     = r_head;
  assign o_valid    = w_valid;
  assign o_fwd_cnt  = r_fwd_cnt;
  assign o_drop_cnt = r_drop_cnt;
  assign o_busy     = w_valid || !fifo_rdempty;

endmodule

// File: doc/desc_fifo_reader.md
# desc_fifo_reader

Drains a 22-bit synchronous show-ahead descriptor FIFO (16 deep) and presents descriptors downstream on a valid/ready interface through a 2-entry output buffer. It sits on the read port of the descriptor FIFO and is the consumer of that FIFO. Descriptors flagged for discard are popped and counted but not forwarded. Forwarded and dropped descriptors are counted for management readout.

## Interface
- DataWidth, 22, descriptor width; bit DataWidth-1 is the discard flag
- CntWidth, 16, width of the statistics counters

- clk  in  1  single clock for all logic
- aclr  in  1  reset, synchronous, active-high
- i_enable  in  1  1 = popping allowed; 0 = pause pops only
- fifo_q  in  DataWidth  FIFO show-ahead head word, valid while fifo_rdempty=0
- fifo_rdempty  in  1  FIFO empty flag
- fifo_rdreq  out  1  FIFO pop; combinational from registered state and FIFO flags
- o_data  out  DataWidth  head descriptor of the output buffer
- o_valid  out  1  o_data is valid
- i_ready  in  1  downstream accepts o_data
- o_fwd_cnt  out  CntWidth  count of descriptors accepted downstream
- o_drop_cnt  out  CntWidth  count of discarded descriptors
- o_busy  out  1  buffer non-empty or FIFO non-empty

## Operation
- FIFO contract: show-ahead. fifo_q/fifo_rdempty update at the same edge that samples fifo_rdreq=1, so back-to-back pops are legal.
- Output buffer: 2 registers (head, tail) plus occupancy count 0..2. Writes are in order; reads always come from the head.
- Output handshake:
  - o_valid = (count != 0); o_data = head register.
  - A transfer happens on a cycle with o_valid & i_ready.
  - While o_valid & !i_ready, o_data and o_valid hold stable.
- Pop condition: fifo_rdreq = !aclr & i_enable & !fifo_rdempty & (fifo_q[DataWidth-1] | count < 2).
- Popped word with discard flag = 1:
  - Not written to the buffer.
  - o_drop_cnt += 1.
  - Discards may be popped even when the buffer is full.
- Popped word with discard flag = 0: written to the buffer.
- Each cycle: count_next = count + (forward pop) - (transfer). Transfer and forward pop in the same cycle:
  - count=1: new word becomes head; count stays 1.
  - count=2: head <= tail. This cannot occur, because pops are blocked at count=2.
- o_fwd_cnt += 1 on each transfer.
- Both counters wrap modulo 2^CntWidth and never saturate.
- i_enable=0 mid-stream: no further pops. Buffered entries still drain normally. Counters keep counting.
- o_busy = (count != 0) | !fifo_rdempty.

## Timing
- Reset (aclr=1 at a clock edge), values from the next cycle:
  - count=0, o_valid=0, o_data=0, o_fwd_cnt=0, o_drop_cnt=0.
  - fifo_rdreq is forced to 0 in every cycle where aclr=1.
- Reset mid-operation: buffered descriptors are lost, not counted, and not popped again. FIFO state is owned by the FIFO's own reset.
- Latency: FIFO head present at cycle N with count=0 and i_enable=1 → fifo_rdreq=1 in N → o_valid=1 in N+1 with o_data = that word.
- Throughput: with i_ready held at 1, one descriptor per cycle is sustained. count stays at 1.
- Backpressure:
  - i_ready=0 with a non-empty FIFO: count reaches 2 after 2 forward pops.
  - After that, fifo_rdreq=0 until a transfer occurs, except when the head word is a discard.
- Discard at head while count=2: popped in that cycle. o_drop_cnt increments on the next edge. Buffer unchanged.
- Counter wrap: all-ones + 1 → 0 on the same edge as the event.

## Test plan
- Reset, then push 0x000001..0x000005 with i_ready=1 → o_valid rises 1 cycle after the first pop; words appear in 5 consecutive cycles in order; o_fwd_cnt=5, o_drop_cnt=0, then o_busy=0.
- Push 4 words with i_ready=0 → exactly 2 pops, o_data=0x000001 held stable, 2 words remain in FIFO; raise i_ready → remaining words 0x000002..0x000004 follow in order; o_fwd_cnt=4.
- Alternate words 0x200001, 0x000002, 0x200003, 0x000004 (discard flag on odd entries) with i_ready=0 → o_drop_cnt=2 and buffer holds 0x000002, 0x000004; release i_ready → o_fwd_cnt=2.
- Stream with i_enable toggled to 0 for 3 cycles mid-stream → fifo_rdreq=0 during the pause; buffered words still delivered; no loss or duplication across 10 words.
- aclr pulsed for 1 cycle with count=2 → o_valid=0, both counters 0 on the next cycle, fifo_rdreq=0 during aclr; popping resumes the following cycle.
- Preset traffic of 65536 forwards → o_fwd_cnt wraps to 0 on the 65536th transfer.
